// File: rtl/skinny_masked_pkg.sv
// Shared constants for the masked SKINNY-64 S-box: reference tables and the per-step bit wiring.
// Each step XORs NOR(b3,b2) into b0; forward steps 0..2 then rotate left, inverse steps 1..3 first rotate right.
package skinny_masked_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int NUM_STAGES = 4;

  localparam logic [3:0] SBOX_FWD [16] = '{
    4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
    4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hA, 4'h1, 4'hE,
    4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hB, 4'hD, 4'hF
  };

  // Bit s set: step s of that direction applies its rotation.
  localparam logic [NUM_STAGES-1:0] FWD_POST_ROTL = 4'b0111;
  localparam logic [NUM_STAGES-1:0] INV_PRE_ROTR  = 4'b1110;

  function automatic logic [3:0] step_pre(input logic [1:0] s, input logic inv, input logic [3:0] x);
    return (inv && INV_PRE_ROTR[s]) ? {x[0], x[3:1]} : x;
  endfunction

  function automatic logic [3:0] step_post(input logic [1:0] s, input logic inv, input logic [3:0] x);
    return (!inv && FWD_POST_ROTL[s]) ? {x[2:0], x[3]} : x;
  endfunction

endpackage

// File: rtl/skinny_sbox_masked_lanes_if.sv
// Handshake and share buses of the masked S-box layer; master drives the inputs, slave is the block.
interface skinny_sbox_masked_lanes_if
  import skinny_masked_pkg::*;
#(
  parameter int LANES = 16
);
  localparam int W = NIBBLE_W * LANES;

  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic [W-1:0] r;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out0;
  logic [W-1:0] out1;

  modport master (
    output in_valid, in_inv, in0, in1, r, out_ready,
    input  in_ready, out_valid, out0, out1
  );

  modport slave (
    input  in_valid, in_inv, in0, in1, r, out_ready,
    output in_ready, out_valid, out0, out1
  );
endinterface

// File: rtl/dom_nor_2s.sv
// Single-bit 2-share NOR with a DOM-indep AND; every partial product is registered before shares meet.
// One cycle latency when en is high; all four registers hold while en is low.
module dom_nor_2s (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic z,
  output logic q0,
  output logic q1
);
  logic inner0, inner1, cross01, cross10;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner0  <= 1'b0;
      inner1  <= 1'b0;
      cross01 <= 1'b0;
      cross10 <= 1'b0;
    end else if (en) begin
      inner0  <= 1'b1 ^ a0 ^ b0 ^ (a0 & b0);
      inner1  <= a1 ^ b1 ^ (a1 & b1);
      cross01 <= (a0 & b1) ^ z;
      cross10 <= (a1 & b0) ^ z;
    end
  end

  // Each output only combines registers of its own domain.
  assign q0 = inner0 ^ cross01;
  assign q1 = inner1 ^ cross10;
endmodule

// File: rtl/skinny_sbox_masked_lanes.sv
// Four-stage 2-share SKINNY-64 S-box layer over LANES nibbles, forward or inverse per transaction; 4-cycle latency.
// Whole pipe advances when the output is empty or taken; otherwise every register holds and in_ready drops.
module skinny_sbox_masked_lanes
  import skinny_masked_pkg::*;
#(
  parameter int LANES = 16
) (
  input logic clk,
  input logic rst_n,
  skinny_sbox_masked_lanes_if.slave bus
);
  localparam int W      = NIBBLE_W * LANES;
  localparam int RAND_W = NIBBLE_W * LANES;

  logic                          en;
  logic [RAND_W-1:0]             rnd;
  logic [NUM_STAGES-1:0]         vld_q;
  logic [NUM_STAGES-1:0]         inv_q;
  logic [NUM_STAGES-1:0]         mode_in;
  logic [NUM_STAGES:0][W-1:0]    sh0;
  logic [NUM_STAGES:0][W-1:0]    sh1;

  assign en            = ~vld_q[NUM_STAGES-1] | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_q[NUM_STAGES-1];
  assign bus.out0      = sh0[NUM_STAGES];
  assign bus.out1      = sh1[NUM_STAGES];
  assign rnd           = bus.r;
  assign sh0[0]        = bus.in0;
  assign sh1[0]        = bus.in1;
  assign mode_in       = {inv_q[NUM_STAGES-2:0], bus.in_inv};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      inv_q <= '0;
    end else if (en) begin
      vld_q <= {vld_q[NUM_STAGES-2:0], bus.in_valid};
      inv_q <= {inv_q[NUM_STAGES-2:0], bus.in_inv};
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    logic [W-1:0]     pre0, pre1;
    logic [W-1:0]     p0_q, p1_q;
    logic [LANES-1:0] nq0, nq1;

    // Bubbles load too, so a stage never carries stale shares forward.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p0_q <= '0;
        p1_q <= '0;
      end else if (en) begin
        p0_q <= pre0;
        p1_q <= pre1;
      end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign pre0[NIBBLE_W*k +: NIBBLE_W] = step_pre(2'(s), mode_in[s], sh0[s][NIBBLE_W*k +: NIBBLE_W]);
      assign pre1[NIBBLE_W*k +: NIBBLE_W] = step_pre(2'(s), mode_in[s], sh1[s][NIBBLE_W*k +: NIBBLE_W]);

      dom_nor_2s u_nor (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a0    (pre0[NIBBLE_W*k+3]),
        .a1    (pre1[NIBBLE_W*k+3]),
        .b0    (pre0[NIBBLE_W*k+2]),
        .b1    (pre1[NIBBLE_W*k+2]),
        .z     (rnd[s*LANES+k]),
        .q0    (nq0[k]),
        .q1    (nq1[k])
      );

      assign sh0[s+1][NIBBLE_W*k +: NIBBLE_W] =
        step_post(2'(s), inv_q[s], {p0_q[NIBBLE_W*k+1 +: 3], p0_q[NIBBLE_W*k] ^ nq0[k]});
      assign sh1[s+1][NIBBLE_W*k +: NIBBLE_W] =
        step_post(2'(s), inv_q[s], {p1_q[NIBBLE_W*k+1 +: 3], p1_q[NIBBLE_W*k] ^ nq1[k]});
    end
  end
endmodule

// File: tb/tb_skinny_sbox_masked_lanes.sv
// Scoreboard bench for the masked S-box layer: table reference per lane, handshake, stall and reset scenarios.
module tb_skinny_sbox_masked_lanes;
  import skinny_masked_pkg::*;

  localparam int LANES = 16;
  localparam int W     = NIBBLE_W * LANES;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  skinny_sbox_masked_lanes_if #(.LANES(LANES)) bus();

  skinny_sbox_masked_lanes #(.LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_out   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] last0, last1;

  function automatic logic [W-1:0] ref_layer(input logic [W-1:0] x, input logic inv);
    logic [W-1:0] y;
    logic [3:0]   nib;
    y = '0;
    for (int k = 0; k < LANES; k++) begin
      nib = x[4*k +: 4];
      y[4*k +: 4] = inv ? SBOX_INV[nib] : SBOX_FWD[nib];
    end
    return y;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom};
  endfunction

  // Scoreboard consumer: every output transfer is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_out++;
      n_tests++;
      last0 = bus.out0;
      last1 = bus.out1;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got %h, no result expected", bus.out0 ^ bus.out1);
      end else begin
        mon_exp = exp_q.pop_front();
        if ((bus.out0 ^ bus.out1) !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_data: got %h required %h", bus.out0 ^ bus.out1, mon_exp);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] s0, input logic [W-1:0] x, input logic inv, input logic [W-1:0] rr);
    int waited = 0;
    bus.in0      = s0;
    bus.in1      = s0 ^ x;
    bus.in_inv   = inv;
    bus.r        = rr;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, waited);
    end else begin
      exp_q.push_back(ref_layer(x, inv));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #20;
    n_tests += 4;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_in_ready: got %b required 1", bus.in_ready); end
    if (bus.out0 !== '0)        begin n_fail++; $display("FAIL rst_out0: got %h required 0", bus.out0); end
    if (bus.out1 !== '0)        begin n_fail++; $display("FAIL rst_out1: got %h required 0", bus.out1); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_latency();
    logic [W-1:0] c_all;
    c_all = {LANES{4'hC}};
    bus.in0 = '0; bus.in1 = '0; bus.r = '0; bus.in_inv = 1'b0; bus.in_valid = 1'b1;
    exp_q.push_back(c_all);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: out_valid=%b required 0", bus.out_valid); end
    @(posedge clk);
    #1;
    n_tests += 2;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid: out_valid=%b required 1", bus.out_valid); end
    if ((bus.out0 ^ bus.out1) !== c_all) begin
      n_fail++;
      $display("FAIL lat_data: got %h required %h", bus.out0 ^ bus.out1, c_all);
    end
    drain();
  endtask

  task automatic test_exhaustive();
    logic [W-1:0] x;
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 16; v++) begin
        for (int k = 0; k < LANES; k++) x[4*k +: 4] = 4'(v + k);
        send(rnd_w(), x, 1'(m), rnd_w());
      end
    end
    send(rnd_w(), {LANES{4'hC}}, 1'b1, rnd_w());
    send(rnd_w(), {LANES{4'hF}}, 1'b0, rnd_w());
    send(rnd_w(), {LANES{4'hF}}, 1'b1, rnd_w());
    drain();
  endtask

  task automatic test_back_to_back_alternate();
    int n0, a, b;
    n0 = n_out;
    a  = 0;
    b  = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 8)  a = n_out;
      if (i == 40) b = n_out;
      send(rnd_w(), rnd_w(), 1'(i % 2), rnd_w());
    end
    drain();
    n_tests += 2;
    if (b - a != 32) begin n_fail++; $display("FAIL alt_rate: %0d results in 32 cycles, required 32", b - a); end
    if (n_out - n0 != 64) begin n_fail++; $display("FAIL alt_count: %0d results, required 64", n_out - n0); end
  endtask

  task automatic test_stall();
    int n0, bad;
    logic [W-1:0] s0, s1;
    n0 = n_out;
    bad = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(rnd_w(), rnd_w(), 1'(i % 2), rnd_w());
    n_tests += 2;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_full: out_valid=%b required 1", bus.out_valid); end
    if (bus.in_ready !== 1'b0)  begin n_fail++; $display("FAIL stall_ready: in_ready=%b required 0", bus.in_ready); end
    s0 = bus.out0;
    s1 = bus.out1;
    repeat (10) begin
      bus.r = rnd_w();
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.out0 !== s0 || bus.out1 !== s1) bad++;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL stall_hold: %0d cycles changed, required 0", bad); end
    bus.out_ready = 1'b1;
    drain();
    n_tests++;
    if (n_out - n0 != 4) begin n_fail++; $display("FAIL stall_count: %0d results, required 4", n_out - n0); end
  endtask

  task automatic test_reset_midflight();
    int n0;
    for (int i = 0; i < 3; i++) send(rnd_w(), rnd_w(), 1'(i % 2), rnd_w());
    n0 = n_out;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: out_valid=%b required 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    n_tests += 2;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: out_valid=%b required 0", bus.out_valid); end
    if (bus.out0 !== '0)        begin n_fail++; $display("FAIL mid_rst_out0: got %h required 0", bus.out0); end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_tests++;
    if (n_out != n0) begin n_fail++; $display("FAIL mid_ghost: %0d results after reset, required 0", n_out - n0); end
    send(rnd_w(), rnd_w(), 1'b1, rnd_w());
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lat_early: out_valid=%b required 0", bus.out_valid); end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_lat: out_valid=%b required 1", bus.out_valid); end
    drain();
  endtask

  task automatic test_share_glitch();
    logic [W-1:0] s0, x, ra, rb, m3, a0, a1, b0, b1;
    s0 = rnd_w() | 64'h1;
    x  = rnd_w();
    ra = rnd_w();
    m3 = '0;
    m3[3*LANES +: LANES] = '1;
    rb = ra ^ m3;
    send(s0, x, 1'b0, ra);
    drain();
    a0 = last0; a1 = last1;
    send(s0, x, 1'b0, rb);
    drain();
    b0 = last0; b1 = last1;
    n_tests += 2;
    if ((a0 ^ b0) !== {LANES{4'h1}}) begin
      n_fail++;
      $display("FAIL glitch_share0: out0 delta %h required %h", a0 ^ b0, {LANES{4'h1}});
    end
    if ((a0 ^ a1) !== (b0 ^ b1)) begin
      n_fail++;
      $display("FAIL glitch_value: %h vs %h, required equal", a0 ^ a1, b0 ^ b1);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_inv    = 1'b0;
    bus.in0       = '0;
    bus.in1       = '0;
    bus.r         = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_zero_latency();
    test_exhaustive();
    test_back_to_back_alternate();
    test_stall();
    test_reset_midflight();
    test_share_glitch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
